// File: rtl/nco_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl_pkg
//   Shared definitions for the NCO sweep controller:
//     - sweep mode encodings (cfg_mode)
//     - FSM state encodings
//     - FTW width derivation from the NCO LUT address width
// -----------------------------------------------------------------------------
package nco_sweep_ctrl_pkg;

    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;
    localparam logic [1:0] MODE_FIXED    = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Integer part is LUTSIZE+1 bits, fraction is 8 bits.
    function automatic int ftw_width(input int lutsize);
        return lutsize + 9;
    endfunction

endpackage

// File: rtl/nco_dwell_timer.sv
// -----------------------------------------------------------------------------
// nco_dwell_timer
//   Loadable down-counter that measures how long each tuning word is held.
//   Loading value D makes zero assert D cycles later, so a word loaded together
//   with the counter is visible for D+1 cycles before the step edge.
// Ports
//   clk       in   system clock (rising edge)
//   rst_n     in   asynchronous active-low reset
//   load      in   load load_val this cycle (takes priority over counting)
//   load_val  in   DWELL_W  value to load
//   zero      out  counter is at zero (holds at zero until reloaded)
// -----------------------------------------------------------------------------
module nco_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!zero) begin
            cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl
//   Sequences the NCO frequency tuning word {int, 8-bit frac} through linear
//   sweeps (single, repeat/sawtooth, triangle, fixed tone). Each word is held
//   for cfg_dwell+1 cycles; steps clamp exactly onto the stop word.
// Ports
//   clk        in   system clock (rising edge)
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse: latch cfg_* and begin sweep (only honoured in IDLE)
//   abort      in   pulse: stop sweep, return to IDLE (wins over start)
//   cfg_start  in   FTW_W    first tuning word
//   cfg_stop   in   FTW_W    final tuning word
//   cfg_step   in   FTW_W    per-step increment magnitude
//   cfg_dwell  in   DWELL_W  words held cfg_dwell+1 cycles
//   cfg_mode   in   2        0 single, 1 repeat, 2 triangle, 3 fixed
//   nco_en     out  NCO enable (= busy)
//   iftw       out  integer tuning word ftw[FTW_W-1:8]
//   fftw       out  fractional tuning word ftw[7:0]
//   busy       out  sweep active
//   done       out  one-cycle pulse at end of a single sweep
//   dir_down   out  current direction, 1 = decreasing
// -----------------------------------------------------------------------------
module nco_sweep_ctrl
    import nco_sweep_ctrl_pkg::*;
#(
    parameter  int LUTSIZE = 10,
    parameter  int DWELL_W = 16,
    localparam int FTW_W   = ftw_width(LUTSIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FTW_W-1:0]   cfg_start,
    input  logic [FTW_W-1:0]   cfg_stop,
    input  logic [FTW_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    output logic               nco_en,
    output logic [LUTSIZE:0]   iftw,
    output logic [7:0]         fftw,
    output logic               busy,
    output logic               done,
    output logic               dir_down
);

    logic [0:0]         state_q, state_d;
    logic [FTW_W-1:0]   ftw_q,   ftw_d;
    logic [FTW_W-1:0]   org_q,   org_d;    // endpoint the current leg started from
    logic [FTW_W-1:0]   tgt_q,   tgt_d;    // endpoint the current leg heads towards
    logic [FTW_W-1:0]   step_q,  step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         mode_q,  mode_d;
    logic               dir_q,   dir_d;
    logic               hold_q,  hold_d;   // degenerate sweep: sit on start word
    logic               done_q,  done_d;

    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_val;
    logic               tmr_zero;

    // One step from cur towards tgt, computed one bit wider so that carry or
    // borrow out of the FTW range is seen and clamped rather than wrapped.
    function automatic logic [FTW_W-1:0] next_word(
        input logic [FTW_W-1:0] cur,
        input logic [FTW_W-1:0] stp,
        input logic [FTW_W-1:0] tgt,
        input logic             down
    );
        logic [FTW_W:0] ext;
        if (down) begin
            ext = {1'b0, cur} - {1'b0, stp};
            if (ext[FTW_W] || (ext[FTW_W-1:0] <= tgt)) begin
                return tgt;
            end
        end else begin
            ext = {1'b0, cur} + {1'b0, stp};
            if (ext[FTW_W] || (ext[FTW_W-1:0] >= tgt)) begin
                return tgt;
            end
        end
        return ext[FTW_W-1:0];
    endfunction

    nco_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        ftw_d    = ftw_q;
        org_d    = org_q;
        tgt_d    = tgt_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        hold_d   = hold_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = dwell_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d  = ST_RUN;
                    ftw_d    = cfg_start;
                    org_d    = cfg_start;
                    tgt_d    = cfg_stop;
                    step_d   = cfg_step;
                    dwell_d  = cfg_dwell;
                    mode_d   = cfg_mode;
                    dir_d    = (cfg_start > cfg_stop);
                    hold_d   = (cfg_mode == MODE_FIXED) || (cfg_step == '0) ||
                               (cfg_start == cfg_stop);
                    tmr_load = 1'b1;
                    tmr_val  = cfg_dwell;
                end
            end
            default: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!hold_q && tmr_zero) begin
                    tmr_load = 1'b1;
                    if (ftw_q == tgt_q) begin
                        // Endpoint has served its full dwell.
                        case (mode_q)
                            MODE_SINGLE: begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                            MODE_REPEAT: begin
                                ftw_d = org_q;
                            end
                            MODE_TRIANGLE: begin
                                // Step away immediately so the endpoint is
                                // not held for a second dwell.
                                org_d = tgt_q;
                                tgt_d = org_q;
                                dir_d = ~dir_q;
                                ftw_d = next_word(ftw_q, step_q, org_q, ~dir_q);
                            end
                            default: begin
                            end
                        endcase
                    end else begin
                        ftw_d = next_word(ftw_q, step_q, tgt_q, dir_q);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ftw_q   <= '0;
            org_q   <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            mode_q  <= '0;
            dir_q   <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ftw_q   <= ftw_d;
            org_q   <= org_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign nco_en   = busy;
    assign done     = done_q;
    assign dir_down = dir_q;
    assign iftw     = ftw_q[FTW_W-1:8];
    assign fftw     = ftw_q[7:0];

endmodule
